// File: rtl/game_pkg.sv
// Shared types and widths for the game-flow sequencer.
//   game_state_t : 3-bit game-flow state encoding (also driven on game_state)
//   LEVEL_W      : width of the level index
//   FRAME_CNT_W  : width of the DYING/WIN frame counter
package game_pkg;

  localparam int LEVEL_W     = 2;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic [2:0] {
    TITLE = 3'd0,
    SPAWN = 3'd1,
    PLAY  = 3'd2,
    DYING = 3'd3,
    WIN   = 3'd4,
    DONE  = 3'd5
  } game_state_t;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector.
//   Clk   : system clock
//   Reset : synchronous, active-high reset (clears history and pulse)
//   d     : level input sampled on Clk
//   pulse : one-cycle pulse, registered, the cycle after d is first seen high
module rise_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      d_q   <= 1'b0;
      pulse <= 1'b0;
    end else begin
      d_q   <= d;
      pulse <= d & ~d_q;
    end
  end

endmodule

// File: rtl/game_flow_controller.sv
// Game-flow sequencer for the player datapath.
// Owns the TITLE/SPAWN/PLAY/DYING/WIN/DONE state machine, the level index and
// the frame counter that times the death and win pauses. Emits a one-cycle
// revive pulse in SPAWN and passes the player keys through only in PLAY.
//   Clk, Reset                         : clock, synchronous active-high reset
//   frame_clk                          : frame-rate clock, edge-detected on Clk
//   start                              : start key (rising edge used)
//   fireboy_dead, icegirl_dead         : hazard contact flags
//   fireboy_at_door, icegirl_at_door   : players inside their exit doors
//   {fb,ig}_{jump,left,right}_in       : raw keys
//   {fb,ig}_{jump,left,right}          : keys gated to PLAY
//   revive                             : reload pulse to both players
//   game_state, level                  : current state and 0-based level
module game_flow_controller
  import game_pkg::*;
#(
  parameter int DEATH_FRAMES = 60,
  parameter int WIN_FRAMES   = 120,
  parameter int NUM_LEVELS   = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         frame_clk,
  input  logic         start,
  input  logic         fireboy_dead,
  input  logic         icegirl_dead,
  input  logic         fireboy_at_door,
  input  logic         icegirl_at_door,
  input  logic         fb_jump_in,
  input  logic         fb_left_in,
  input  logic         fb_right_in,
  input  logic         ig_jump_in,
  input  logic         ig_left_in,
  input  logic         ig_right_in,
  output logic         fb_jump,
  output logic         fb_left,
  output logic         fb_right,
  output logic         ig_jump,
  output logic         ig_left,
  output logic         ig_right,
  output logic         revive,
  output logic [2:0]   game_state,
  output logic [1:0]   level
);

  localparam logic [FRAME_CNT_W-1:0] DEATH_LAST = FRAME_CNT_W'(DEATH_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] WIN_LAST   = FRAME_CNT_W'(WIN_FRAMES - 1);
  localparam logic [LEVEL_W-1:0]     LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);

  game_state_t            state_q, state_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [LEVEL_W-1:0]     level_q;
  logic                   frame_edge, start_edge;
  logic                   play_en;

  // frame_edge lags frame_clk by one Clk, same as the players' own detector,
  // so a revive reload always lands before their next frame update.
  rise_detect u_frame_rd (.Clk(Clk), .Reset(Reset), .d(frame_clk), .pulse(frame_edge));
  rise_detect u_start_rd (.Clk(Clk), .Reset(Reset), .d(start),     .pulse(start_edge));

  wire any_dead  = fireboy_dead | icegirl_dead;
  wire both_door = fireboy_at_door & icegirl_at_door;
  // Exit on the N-th edge: counter holds N-1 edges seen so far.
  wire death_end = frame_edge && (frame_cnt_q == DEATH_LAST);
  wire win_end   = frame_edge && (frame_cnt_q == WIN_LAST);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= TITLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      TITLE: if (start_edge) state_d = SPAWN;
      SPAWN: state_d = PLAY;
      PLAY: begin
        // death wins over a same-cycle door arrival
        if (any_dead)                     state_d = DYING;
        else if (both_door && frame_edge) state_d = WIN;
      end
      DYING: if (death_end) state_d = SPAWN;
      WIN:   if (win_end)   state_d = (level_q == LAST_LEVEL) ? DONE : SPAWN;
      DONE:  if (start_edge) state_d = SPAWN;
      default: state_d = TITLE;  // 6/7 are illegal
    endcase
  end

  // Frame counter: zeroed on entry to a timed state, counts edges inside it.
  always_ff @(posedge Clk) begin
    if (Reset)
      frame_cnt_q <= '0;
    else if ((state_d == DYING || state_d == WIN) && state_d != state_q)
      frame_cnt_q <= '0;
    else if ((state_q == DYING || state_q == WIN) && frame_edge)
      frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
  end

  // Level changes on the edge that enters SPAWN, so it is stable under revive.
  always_ff @(posedge Clk) begin
    if (Reset)
      level_q <= '0;
    else if (state_q == WIN && state_d == SPAWN)
      level_q <= level_q + LEVEL_W'(1);
    else if (state_q == DONE && state_d == SPAWN)
      level_q <= '0;
  end

  // Outputs; held at their idle values while Reset is asserted.
  always_comb begin
    revive     = 1'b0;
    play_en    = 1'b0;
    game_state = 3'd0;
    if (!Reset) begin
      revive     = (state_q == SPAWN);
      play_en    = (state_q == PLAY);
      game_state = state_q;
    end
    fb_jump  = fb_jump_in  & play_en;
    fb_left  = fb_left_in  & play_en;
    fb_right = fb_right_in & play_en;
    ig_jump  = ig_jump_in  & play_en;
    ig_left  = ig_left_in  & play_en;
    ig_right = ig_right_in & play_en;
  end

  assign level = level_q;

endmodule

// File: tb/tb_game_flow_controller.sv
module tb_game_flow_controller;

  localparam logic [2:0] S_TITLE = 3'd0, S_SPAWN = 3'd1, S_PLAY = 3'd2,
                         S_DYING = 3'd3, S_WIN = 3'd4, S_DONE = 3'd5;
  // {fb_jump, fb_left, fb_right, ig_jump, ig_left, ig_right} held during the run
  localparam logic [5:0] KEYS = 6'b110001;

  logic Clk = 1'b0;
  logic Reset, frame_clk, start;
  logic fireboy_dead, icegirl_dead, fireboy_at_door, icegirl_at_door;
  logic fb_jump_in, fb_left_in, fb_right_in, ig_jump_in, ig_left_in, ig_right_in;
  logic fb_jump, fb_left, fb_right, ig_jump, ig_left, ig_right;
  logic revive;
  logic [2:0] game_state;
  logic [1:0] level;

  always #5 Clk = ~Clk;

  game_flow_controller #(.DEATH_FRAMES(60), .WIN_FRAMES(120), .NUM_LEVELS(3)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
    .fireboy_dead(fireboy_dead), .icegirl_dead(icegirl_dead),
    .fireboy_at_door(fireboy_at_door), .icegirl_at_door(icegirl_at_door),
    .fb_jump_in(fb_jump_in), .fb_left_in(fb_left_in), .fb_right_in(fb_right_in),
    .ig_jump_in(ig_jump_in), .ig_left_in(ig_left_in), .ig_right_in(ig_right_in),
    .fb_jump(fb_jump), .fb_left(fb_left), .fb_right(fb_right),
    .ig_jump(ig_jump), .ig_left(ig_left), .ig_right(ig_right),
    .revive(revive), .game_state(game_state), .level(level)
  );

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic [1:0] lvl;
    logic       rev;
    logic [5:0] ctl;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_err = 0;
  int   cyc = 0;
  int   rev_exp = 0, rev_seen = 0, rev_dbl = 0;
  logic rev_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp_v);
    end
  endtask

  // push an expected output snapshot for cycle cyc+dly, kept in cycle order
  task automatic exp_at(input int dly, input logic [2:0] st, input logic [1:0] lvl,
                        input logic rev, input logic [5:0] ctl);
    exp_t e;
    int   i;
    e.cyc = cyc + dly; e.st = st; e.lvl = lvl; e.rev = rev; e.ctl = ctl;
    if (rev) rev_exp++;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
    sb.insert(i, e);
  endtask

  task automatic exp_now(input logic [2:0] st, input logic [1:0] lvl,
                         input logic rev, input logic [5:0] ctl);
    exp_at(0, st, lvl, rev, ctl);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // monitor: pop expectations due this cycle, track revive behaviour
  always @(negedge Clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("state@%0d", e.cyc), {29'd0, game_state}, {29'd0, e.st});
      chk($sformatf("level@%0d", e.cyc), {30'd0, level}, {30'd0, e.lvl});
      chk($sformatf("revive@%0d", e.cyc), {31'd0, revive}, {31'd0, e.rev});
      chk($sformatf("ctl@%0d", e.cyc),
          {26'd0, fb_jump, fb_left, fb_right, ig_jump, ig_left, ig_right}, {26'd0, e.ctl});
    end
    if (revive) rev_seen <= rev_seen + 1;
    if (revive && rev_prev) rev_dbl <= rev_dbl + 1;
    rev_prev <= revive;
  end

  // n frame_clk periods of 2 cycles each; state expected unchanged throughout
  task automatic frames(input int n, input logic [2:0] st, input logic [1:0] lvl);
    for (int k = 0; k < n; k++) begin
      frame_clk = 1'b1; exp_now(st, lvl, 1'b0, (st == S_PLAY) ? KEYS : 6'd0);
      tick();
      frame_clk = 1'b0; exp_now(st, lvl, 1'b0, (st == S_PLAY) ? KEYS : 6'd0);
      tick();
    end
  endtask

  // one-cycle death flag in PLAY, full death pause, respawn
  task automatic die(input logic [1:0] lvl, input bit fb);
    if (fb) fireboy_dead = 1'b1; else icegirl_dead = 1'b1;
    exp_now(S_PLAY, lvl, 1'b0, KEYS);
    tick();
    fireboy_dead = 1'b0; icegirl_dead = 1'b0;
    frames(60, S_DYING, lvl);
    exp_now(S_SPAWN, lvl, 1'b1, 6'd0);
    tick();
    exp_now(S_PLAY, lvl, 1'b0, KEYS);
  endtask

  // both doors, first without a frame edge (no effect), then on an edge
  task automatic enter_win(input logic [1:0] lvl);
    fireboy_at_door = 1'b1; icegirl_at_door = 1'b1;
    exp_now(S_PLAY, lvl, 1'b0, KEYS);
    tick();
    exp_now(S_PLAY, lvl, 1'b0, KEYS);
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
    exp_now(S_PLAY, lvl, 1'b0, KEYS);
    tick();
    fireboy_at_door = 1'b0; icegirl_at_door = 1'b0;
  endtask

  task automatic do_win(input logic [1:0] lvl, input bit last);
    enter_win(lvl);
    frames(120, S_WIN, lvl);
    if (!last) begin
      exp_now(S_SPAWN, lvl + 2'd1, 1'b1, 6'd0);
      tick();
      exp_now(S_PLAY, lvl + 2'd1, 1'b0, KEYS);
    end else begin
      exp_now(S_DONE, lvl, 1'b0, 6'd0);
      tick();
      exp_now(S_DONE, lvl, 1'b0, 6'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; start = 1'b0;
    fireboy_dead = 1'b0; icegirl_dead = 1'b0;
    fireboy_at_door = 1'b0; icegirl_at_door = 1'b0;
    {fb_jump_in, fb_left_in, fb_right_in, ig_jump_in, ig_left_in, ig_right_in} = KEYS;

    // reset state, keys held but gated
    tick(); exp_now(S_TITLE, 2'd0, 1'b0, 6'd0);
    tick(); Reset = 1'b0; exp_now(S_TITLE, 2'd0, 1'b0, 6'd0);
    tick(); exp_now(S_TITLE, 2'd0, 1'b0, 6'd0);

    // start held 5 cycles: SPAWN+revive two cycles after the rise, then PLAY
    start = 1'b1;
    exp_at(1, S_TITLE, 2'd0, 1'b0, 6'd0);
    exp_at(2, S_SPAWN, 2'd0, 1'b1, 6'd0);
    exp_at(3, S_PLAY,  2'd0, 1'b0, KEYS);
    repeat (5) tick();
    start = 1'b0;
    exp_now(S_PLAY, 2'd0, 1'b0, KEYS);
    tick();

    // death of one player, 60-edge pause, respawn at same level
    die(2'd0, 1'b0);
    tick();

    // death and both-at-door on the same frame-edge cycle: death wins
    frame_clk = 1'b1; exp_now(S_PLAY, 2'd0, 1'b0, KEYS);
    tick();
    frame_clk = 1'b0;
    fireboy_dead = 1'b1; fireboy_at_door = 1'b1; icegirl_at_door = 1'b1;
    exp_now(S_PLAY, 2'd0, 1'b0, KEYS);
    tick();
    fireboy_dead = 1'b0; fireboy_at_door = 1'b0; icegirl_at_door = 1'b0;
    frames(60, S_DYING, 2'd0);
    exp_now(S_SPAWN, 2'd0, 1'b1, 6'd0);
    tick();
    exp_now(S_PLAY, 2'd0, 1'b0, KEYS);
    tick();

    // clear all three levels
    do_win(2'd0, 1'b0); tick();
    do_win(2'd1, 1'b0); tick();
    do_win(2'd2, 1'b1); tick();
    frames(2, S_DONE, 2'd2);

    // restart from DONE: level back to 0 with revive
    start = 1'b1;
    exp_at(1, S_DONE,  2'd2, 1'b0, 6'd0);
    exp_at(2, S_SPAWN, 2'd0, 1'b1, 6'd0);
    exp_at(3, S_PLAY,  2'd0, 1'b0, KEYS);
    repeat (3) tick();
    start = 1'b0;
    tick();
    exp_now(S_PLAY, 2'd0, 1'b0, KEYS);
    do_win(2'd0, 1'b0); tick();

    // reset 30 frames into a WIN at level 1
    enter_win(2'd1);
    frames(30, S_WIN, 2'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_now(S_TITLE, 2'd0, 1'b0, 6'd0);
    tick();
    exp_now(S_TITLE, 2'd0, 1'b0, 6'd0);
    frames(2, S_TITLE, 2'd0);

    // start held through TITLE->PLAY->DYING->SPAWN->PLAY: one edge only
    start = 1'b1;
    exp_at(1, S_TITLE, 2'd0, 1'b0, 6'd0);
    exp_at(2, S_SPAWN, 2'd0, 1'b1, 6'd0);
    exp_at(3, S_PLAY,  2'd0, 1'b0, KEYS);
    repeat (3) tick();
    die(2'd0, 1'b1);
    repeat (3) begin
      tick();
      exp_now(S_PLAY, 2'd0, 1'b0, KEYS);
    end
    start = 1'b0;
    tick();
    exp_now(S_PLAY, 2'd0, 1'b0, KEYS);

    @(negedge Clk);
    #1;
    chk("sb_drain", sb.size(), 32'd0);
    chk("revive_count", rev_seen, rev_exp);
    chk("revive_consec", rev_dbl, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
